// File: rtl/fifo_uart_pkg.sv
// Shared types and width helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    // Baud counter holds 0..clk_div-1; keep at least one bit for clk_div=2.
    function automatic int baud_cnt_width(input int clk_div);
        return (clk_div > 2) ? $clog2(clk_div) : 1;
    endfunction

    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clk of each CLK_DIV-cycle bit.
module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = baud_cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and sends them as UART frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_r_data,
    output logic             fifo_r_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BIT_W = bit_cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bit_tick;
    logic             baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Restart the bit period on every state change so each state gets whole bits.
    assign baud_clr = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_tick (bit_tick)
    );

    assign fifo_r_en = (state_q == ST_FETCH);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        frame_done = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d   = fifo_r_data;
                bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^fifo_r_data;
`endif
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // The bit counter is reused to count stop bits.
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = (tx_en && !fifo_empty) ? ST_FETCH : ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx = TX_IDLE_LEVEL;
        case (state_q)
            ST_START:  tx = ~TX_IDLE_LEVEL;
            ST_DATA:   tx = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx = parity_q;
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
